// File: rtl/cvxif_vec_issue_ctrl.sv
// CV-X-IF issue controller: pairs OP-V instructions with rs1, queues them and dispatches to the
// vector unit. Optional perf counters when VEC_ISSUE_PERF_EN is defined.
module cvxif_vec_issue_ctrl #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned DEPTH  = 4,
  parameter logic [6:0]  OPCODE = 7'h57
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            issue_valid_i,
  input  logic [31:0]     issue_instr_i,
  input  logic [ID_W-1:0] issue_id_i,
  output logic            issue_ready_o,
  output logic            issue_accept_o,
  output logic            issue_writeback_o,
  input  logic            register_valid_i,
  input  logic [ID_W-1:0] register_id_i,
  input  logic [XLEN-1:0] register_rs1_i,
  output logic            register_ready_o,
  output logic            vec_valid_o,
  output logic [31:0]     vec_instr_o,
  output logic [XLEN-1:0] vec_rs1_o,
  input  logic            vec_full_i,
  output logic            result_valid_o,
  output logic [ID_W-1:0] result_id_o,
  input  logic            result_ready_i,
  output logic            busy_o
`ifdef VEC_ISSUE_PERF_EN
  ,
  output logic [31:0]     perf_dispatch_o,
  output logic [31:0]     perf_stall_o
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  localparam logic S_IDLE     = 1'b0;
  localparam logic S_WAIT_REG = 1'b1;

  logic            state_q, state_d;
  logic [31:0]     stg_instr_q;
  logic [ID_W-1:0] stg_id_q;

  logic [31:0]     mem_instr [DEPTH];
  logic [XLEN-1:0] mem_rs1   [DEPTH];
  logic [ID_W-1:0] mem_id    [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic            issue_hs, direct_push, wait_push, push, pop;
  logic [31:0]     push_instr;
  logic [XLEN-1:0] push_rs1;
  logic [ID_W-1:0] push_id;

  assign issue_ready_o     = (state_q == S_IDLE) && (count_q < DepthC);
  assign issue_accept_o    = issue_instr_i[6:0] == OPCODE;
  assign issue_writeback_o = 1'b0;
  assign register_ready_o  = (state_q == S_WAIT_REG) || issue_ready_o;

  assign issue_hs    = issue_valid_i && issue_ready_o;
  assign direct_push = issue_hs && issue_accept_o && register_valid_i &&
                       (register_id_i == issue_id_i);
  assign wait_push   = (state_q == S_WAIT_REG) && register_valid_i && (register_id_i == stg_id_q);
  assign push        = direct_push || wait_push;
  assign pop         = (count_q != '0) && !vec_full_i && (!result_valid_o || result_ready_i);

  // Only one push source can be active: direct needs S_IDLE, wait needs S_WAIT_REG.
  always_comb begin
    push_instr = stg_instr_q;
    push_id    = stg_id_q;
    push_rs1   = register_rs1_i;
    if (direct_push) begin
      push_instr = issue_instr_i;
      push_id    = issue_id_i;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) begin
      if (issue_hs && issue_accept_o && !direct_push) state_d = S_WAIT_REG;
    end else if (wait_push) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      stg_instr_q <= '0;
      stg_id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (issue_hs && issue_accept_o) begin
        stg_instr_q <= issue_instr_i;
        stg_id_q    <= issue_id_i;
      end
    end
  end

  // Storage needs no reset: entries are only read when count_q says they are valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_instr[wr_ptr_q] <= push_instr;
      mem_rs1[wr_ptr_q]   <= push_rs1;
      mem_id[wr_ptr_q]    <= push_id;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vec_valid_o    <= 1'b0;
      vec_instr_o    <= '0;
      vec_rs1_o      <= '0;
      result_valid_o <= 1'b0;
      result_id_o    <= '0;
    end else begin
      vec_valid_o <= pop;
      if (pop) begin
        vec_instr_o    <= mem_instr[rd_ptr_q];
        vec_rs1_o      <= mem_rs1[rd_ptr_q];
        result_valid_o <= 1'b1;
        result_id_o    <= mem_id[rd_ptr_q];
      end else if (result_ready_i) begin
        result_valid_o <= 1'b0;
      end
    end
  end

  assign busy_o = (state_q != S_IDLE) || (count_q != '0) || result_valid_o;

`ifdef VEC_ISSUE_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_dispatch_o <= '0;
      perf_stall_o    <= '0;
    end else begin
      if (pop) perf_dispatch_o <= perf_dispatch_o + 32'd1;
      if ((count_q != '0) && vec_full_i) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule
